// File: rtl/and_32bits_pkg.sv
// Shared ALU constants: default datapath width and the flag vector layout
// used by the pipelined result/flag path.
package and_32bits_pkg;

  localparam int ALU_WIDTH = 32;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int NUM_FLAGS = 2;

  typedef logic [NUM_FLAGS-1:0] alu_flags_t;

  // After reset the registered result is zero, so only the zero flag is set.
  localparam alu_flags_t FLAGS_RESET = alu_flags_t'(1 << FLAG_ZERO);

endpackage : and_32bits_pkg

// File: rtl/and_32bits_and_1_bit.sv
// Single-bit AND cell; the top module replicates it across the operand width.
module and_1_bit (
  input  logic a,
  input  logic b,
  output logic s
);

  assign s = a & b;

endmodule : and_1_bit

// File: rtl/and_32bits.sv
// Bitwise AND unit: combinational S for the same-cycle result mux, plus a
// registered result with a one-cycle valid pulse and zero/negative flags.
module and_32bits
  import and_32bits_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] S_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             neg_q
);

  logic [WIDTH-1:0] s_comb;
  logic [WIDTH-1:0] s_q_reg;
  logic [WIDTH-1:0] s_q_next;
  alu_flags_t       flags_reg;
  alu_flags_t       flags_next;
  logic             out_valid_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      and_1_bit u_and_1_bit (
        .a (A[gi]),
        .b (B[gi]),
        .s (s_comb[gi])
      );
    end
  endgenerate

  // Without a capture the result and flags simply hold their last value.
  always_comb begin
    s_q_next   = s_q_reg;
    flags_next = flags_reg;
    if (in_valid) begin
      s_q_next              = s_comb;
      flags_next[FLAG_ZERO] = ~|s_comb;
      flags_next[FLAG_NEG]  = s_comb[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q_reg       <= '0;
      flags_reg     <= FLAGS_RESET;
      out_valid_reg <= 1'b0;
    end else begin
      s_q_reg       <= s_q_next;
      flags_reg     <= flags_next;
      out_valid_reg <= in_valid;
    end
  end

  assign S         = s_comb;
  assign S_q       = s_q_reg;
  assign out_valid = out_valid_reg;
  assign zero_q    = flags_reg[FLAG_ZERO];
  assign neg_q     = flags_reg[FLAG_NEG];

endmodule : and_32bits

// File: tb/tb_and_32bits.sv
// Directed-vector bench for and_32bits: combinational result, capture,
// hold, back-to-back streaming and reset-over-capture behaviour.
module tb_and_32bits;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] s;
  logic [31:0] s_q;
  logic        out_valid;
  logic        zero_q;
  logic        neg_q;

  int tests_run    = 0;
  int tests_failed = 0;

  and_32bits #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (a),
    .B         (b),
    .in_valid  (in_valid),
    .S         (s),
    .S_q       (s_q),
    .out_valid (out_valid),
    .zero_q    (zero_q),
    .neg_q     (neg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h (A=%08h B=%08h S=%08h)",
               tag, got, exp, a, b, s);
    end else begin
      $display("ok   %s: %08h (A=%08h B=%08h S=%08h)", tag, got, a, b, s);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back stream: vectors of tests 2 and 3 with hand-computed results.
  logic [31:0] stream_a   [3] = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0003};
  logic [31:0] stream_b   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
  logic [31:0] stream_s   [3] = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
  logic        stream_neg [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 32'h0;
    b        = 32'h0;
    tick();
    tick();
    check("reset_s_q",       s_q,             32'h0);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_zero_q",    {31'h0, zero_q},    32'h1);
    check("reset_neg_q",     {31'h0, neg_q},     32'h0);
    rst = 1'b0;
    tick();

    // Test 1: zero operands
    a = 32'h0; b = 32'h0; in_valid = 1'b1;
    #1;
    check("t1_s", s, 32'h0);
    tick();
    in_valid = 1'b0;
    check("t1_s_q",      s_q,                 32'h0);
    check("t1_out_valid", {31'h0, out_valid}, 32'h1);
    check("t1_zero_q",   {31'h0, zero_q},     32'h1);
    check("t1_neg_q",    {31'h0, neg_q},      32'h0);

    // Test 2: MSB and LSB set
    a = 32'h8000_0001; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    #1;
    check("t2_s", s, 32'h8000_0001);
    tick();
    in_valid = 1'b0;
    check("t2_s_q",       s_q,                32'h8000_0001);
    check("t2_out_valid", {31'h0, out_valid}, 32'h1);
    check("t2_zero_q",    {31'h0, zero_q},    32'h0);
    check("t2_neg_q",     {31'h0, neg_q},     32'h1);

    // Hold: no capture, out_valid drops, registered values persist
    a = 32'h0; b = 32'h0;
    tick();
    check("hold_out_valid", {31'h0, out_valid}, 32'h0);
    check("hold_s_q",       s_q,                32'h8000_0001);
    check("hold_neg_q",     {31'h0, neg_q},     32'h1);
    check("hold_zero_q",    {31'h0, zero_q},    32'h0);

    // Test 3: combinational only
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; #1;
    check("t3_all_ones", s, 32'hFFFF_FFFF);
    a = 32'h0000_0003; b = 32'h0000_0001; #1;
    check("t3_3and1", s, 32'h0000_0001);
    a = 32'h0000_0001; b = 32'h7FFF_FFFF; #1;
    check("t3_1and7f", s, 32'h0000_0001);
    a = 32'hA5A5_5A5A; b = 32'h0FF0_F00F; #1;
    check("t3_mixed", s, 32'h05A0_500A);
    tick();
    check("t3_s_q_untouched", s_q, 32'h8000_0001);

    // Test 4: three consecutive captures
    a = stream_a[0]; b = stream_b[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_s_q_%0d", i),       s_q,                     stream_s[i]);
      check($sformatf("t4_out_valid_%0d", i), {31'h0, out_valid},      32'h1);
      check($sformatf("t4_neg_q_%0d", i),     {31'h0, neg_q},          {31'h0, stream_neg[i]});
      check($sformatf("t4_zero_q_%0d", i),    {31'h0, zero_q},         32'h0);
      if (i < 2) begin
        a = stream_a[i+1]; b = stream_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    check("t4_out_valid_end", {31'h0, out_valid}, 32'h0);
    check("t4_s_q_end",       s_q,                32'h0000_0001);

    // Test 5: reset dominates a coincident capture; S keeps tracking
    rst = 1'b1; in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    #1;
    check("t5_s_during_rst", s, 32'hFFFF_FFFF);
    tick();
    check("t5_s_q",       s_q,                32'h0);
    check("t5_out_valid", {31'h0, out_valid}, 32'h0);
    check("t5_zero_q",    {31'h0, zero_q},    32'h1);
    check("t5_neg_q",     {31'h0, neg_q},     32'h0);
    check("t5_s",         s,                  32'hFFFF_FFFF);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_and_32bits
